fp_round_pipe: RTL and testbench

Pipelined, parametrised IEEE-754 round-to-integral unit and the successor to the combinational single-precision floor block. Exponent and mantissa widths are configurable. The rounding mode is selectable per transaction: truncate, floor, ceil, or round-nearest-even. The block sits between the FP datapath stages behind a valid/ready handshake, so the arithmetic pipeline can stall it.

---
 rtl/fp_round_pkg.sv | 40 ++++
 rtl/fp_round_mask.sv | 34 +++
 rtl/fp_round_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_fp_round_pipe.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_round_pkg.sv
// fp_round_pkg: shared definitions for the fp_round_pipe round-to-integral unit.
//   - rounding mode encodings carried with each operand
//   - operand class enum decoded in the first pipeline stage
//   - helpers deriving bias and word width from EXP_W/MAN_W, plus defaults
// Optional feature macro used by the top: FP_ROUND_INEXACT_EN.
package fp_round_pkg;

    localparam logic [1:0] MODE_TRUNC = 2'b00;
    localparam logic [1:0] MODE_FLOOR = 2'b01;
    localparam logic [1:0] MODE_CEIL  = 2'b10;
    localparam logic [1:0] MODE_RNE   = 2'b11;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    // SPECIAL : Inf/NaN, passes through
    // INTEGRAL: unbiased exponent >= MAN_W, no fraction bits stored
    // FRAC    : 0 <= e < MAN_W, some mantissa bits are fraction
    // SUBONE  : e < 0 (zeros, denormals, |x| < 1)
    typedef enum logic [1:0] {
        CLS_SPECIAL,
        CLS_INTEGRAL,
        CLS_FRAC,
        CLS_SUBONE
    } cls_t;

    function automatic int calc_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int calc_word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // All-ones exponent value for a given exponent width (Inf/NaN marker).
    function automatic int calc_exp_ones(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

endpackage

// File: rtl/fp_round_mask.sv
// fp_round_mask: combinational mask generator for the rounding decode.
// Ports:
//   e          in  EXP_W+1  unbiased exponent, two's complement
//   frac_mask  out MAN_W    ones over the fraction bits man[MAN_W-1-e:0]
//   half_mask  out MAN_W    one-hot at the half-ULP bit man[MAN_W-1-e]
//   ulp_mask   out MAN_W+1  one-hot at the integer LSB (bit MAN_W-e of {1,man})
// Outputs are only meaningful for 0 <= e < MAN_W; the caller ignores them
// otherwise. Negative e is clamped so the shifts stay well defined.
module fp_round_mask
    import fp_round_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic [EXP_W:0]   e,
    output logic [MAN_W-1:0] frac_mask,
    output logic [MAN_W-1:0] half_mask,
    output logic [MAN_W:0]   ulp_mask
);

    localparam logic [MAN_W-1:0] ALL_ONES = '1;
    localparam logic [MAN_W-1:0] HALF_TOP = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [MAN_W:0]   ULP_TOP  = {1'b1, {MAN_W{1'b0}}};

    logic [EXP_W:0] sh;

    always_comb begin
        sh        = e[EXP_W] ? '0 : e;
        frac_mask = ALL_ONES >> sh;
        half_mask = HALF_TOP >> sh;
        ulp_mask  = ULP_TOP >> sh;
    end

endmodule

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: 2-stage pipelined IEEE-754 round-to-integral unit.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake; in_data = {sign, exp, man}
//   in_mode               00 trunc, 01 floor, 10 ceil, 11 round-nearest-even
//   out_valid/out_ready   output handshake; out_data = integral-valued result
//   out_inexact           (only with FP_ROUND_INEXACT_EN) result differs from input
// Handshake: a word moves whenever valid and ready are both high on a rising
// edge. Stage k advances when it is empty or the stage after it advances, so
// in_ready = adv1 and a stalled output holds out_valid/out_data unchanged.
// S1 holds the decoded operand and the round-up decision; S2 holds the packed
// result. Latency is exactly 2 cycles with no backpressure.
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_data,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_data
`ifdef FP_ROUND_INEXACT_EN
    ,
    output logic                     out_inexact
`endif
);

    localparam int W = calc_word_w(EXP_W, MAN_W);
    localparam int BIAS = calc_bias(EXP_W);
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(calc_exp_ones(EXP_W));
    localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] HALF_E = EXP_W'(BIAS - 1);
    localparam logic signed [EXP_W:0] MAN_W_S = (EXP_W+1)'(MAN_W);
    localparam logic [W-2:0] ONE_MAG = {BIAS_E, {MAN_W{1'b0}}};

    // ---------------- decode (feeds S1) ----------------
    logic                    d_sign;
    logic [EXP_W-1:0]        d_exp;
    logic [MAN_W-1:0]        d_man;
    logic signed [EXP_W:0]   d_e;
    logic [MAN_W-1:0]        frac_mask;
    logic [MAN_W-1:0]        half_mask;
    logic [MAN_W:0]          ulp_mask;
    cls_t                    d_cls;
    logic                    d_up;
    logic                    frac_nz;
    logic                    half_set;
    logic                    below_nz;
    logic                    int_lsb;
    logic                    nonzero;

    assign d_sign = in_data[W-1];
    assign d_exp  = in_data[W-2:MAN_W];
    assign d_man  = in_data[MAN_W-1:0];
    assign d_e    = $signed({1'b0, d_exp}) - $signed({1'b0, BIAS_E});

    fp_round_mask #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_mask (
        .e         (d_e),
        .frac_mask (frac_mask),
        .half_mask (half_mask),
        .ulp_mask  (ulp_mask)
    );

    always_comb begin
        frac_nz  = |(d_man & frac_mask);
        half_set = |(d_man & half_mask);
        below_nz = |(d_man & frac_mask & ~half_mask);
        // Integer LSB including the hidden bit, so e = 0 sees an odd integer.
        int_lsb  = |({1'b1, d_man} & ulp_mask);
        nonzero  = |in_data[W-2:0];

        if (d_exp == EXP_ONES)
            d_cls = CLS_SPECIAL;
        else if (d_e >= MAN_W_S)
            d_cls = CLS_INTEGRAL;
        else if (!d_e[EXP_W])
            d_cls = CLS_FRAC;
        else
            d_cls = CLS_SUBONE;

        d_up = 1'b0;
        case (d_cls)
            CLS_FRAC: begin
                case (in_mode)
                    MODE_FLOOR: d_up = d_sign & frac_nz;
                    MODE_CEIL:  d_up = ~d_sign & frac_nz;
                    MODE_RNE:   d_up = half_set & (below_nz | int_lsb);
                    default:    d_up = 1'b0;
                endcase
            end
            CLS_SUBONE: begin
                // For |x| < 1 "up" means the magnitude becomes 1.0.
                case (in_mode)
                    MODE_FLOOR: d_up = d_sign & nonzero;
                    MODE_CEIL:  d_up = ~d_sign & nonzero;
                    MODE_RNE:   d_up = (d_exp == HALF_E) & (|d_man);
                    default:    d_up = 1'b0;
                endcase
            end
            default: d_up = 1'b0;
        endcase
    end

`ifdef FP_ROUND_INEXACT_EN
    logic d_inexact;
    always_comb begin
        case (d_cls)
            CLS_FRAC:   d_inexact = frac_nz;
            CLS_SUBONE: d_inexact = nonzero;
            default:    d_inexact = 1'b0;
        endcase
    end
`endif

    // ---------------- pipeline control ----------------
    logic v1, v2, adv1, adv2;

    assign adv2      = !v2 | out_ready;
    assign adv1      = !v1 | adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // ---------------- S1 registers ----------------
    logic                s1_sign;
    logic [W-2:0]        s1_mag;
    cls_t                s1_cls;
    logic [MAN_W-1:0]    s1_mask;
    logic [MAN_W:0]      s1_ulp;
    logic                s1_up;
`ifdef FP_ROUND_INEXACT_EN
    logic                s1_inexact;
`endif

    // ---------------- S2 packing ----------------
    logic [W-2:0] mask_x;
    logic [W-2:0] ulp_x;
    logic [W-2:0] pack_mag;

    always_comb begin
        mask_x = {{EXP_W{1'b0}}, s1_mask};
        ulp_x  = {{(EXP_W-1){1'b0}}, s1_ulp};
        case (s1_cls)
            // Adding on the joint {exp,man} field lets a mantissa overflow
            // carry straight into the exponent.
            CLS_FRAC:   pack_mag = (s1_mag & ~mask_x) + (s1_up ? ulp_x : '0);
            CLS_SUBONE: pack_mag = s1_up ? ONE_MAG : '0;
            default:    pack_mag = s1_mag;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            s1_sign    <= 1'b0;
            s1_mag     <= '0;
            s1_cls     <= CLS_SPECIAL;
            s1_mask    <= '0;
            s1_ulp     <= '0;
            s1_up      <= 1'b0;
            out_data   <= '0;
`ifdef FP_ROUND_INEXACT_EN
            s1_inexact  <= 1'b0;
            out_inexact <= 1'b0;
`endif
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_sign <= d_sign;
                    s1_mag  <= in_data[W-2:0];
                    s1_cls  <= d_cls;
                    s1_mask <= frac_mask;
                    s1_ulp  <= ulp_mask;
                    s1_up   <= d_up;
`ifdef FP_ROUND_INEXACT_EN
                    s1_inexact <= d_inexact;
`endif
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    out_data <= {s1_sign, pack_mag};
`ifdef FP_ROUND_INEXACT_EN
                    out_inexact <= s1_inexact;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: bench for fp_round_pipe, with a single-precision instance
// (dut_a, EXP_W=8/MAN_W=23) and a double-precision instance (dut_b, 11/52).
// The reference model rounds the operand's integer/remainder split with plain
// arithmetic and re-normalises the integer; it is pinned by literal vectors.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A word transfers when valid and ready are both high at a
// rising edge. Optional feature macro: FP_ROUND_INEXACT_EN.
module tb_fp_round_pipe;
    import fp_round_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared driver signals ----------------
    logic        drv_valid = 1'b0;
    logic [63:0] drv_data = '0;
    logic [1:0]  drv_mode = 2'b00;
    logic        sel = 1'b0;       // 0 drives dut_a, 1 drives dut_b
    logic        out_rdy = 1'b1;
    logic        chk_lat = 1'b0;
    logic        rand_on = 1'b0;

    logic        a_in_valid, a_in_ready, a_out_valid;
    logic [31:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid;
    logic [63:0] b_in_data, b_out_data;
`ifdef FP_ROUND_INEXACT_EN
    logic        a_out_inexact, b_out_inexact;
`endif

    assign a_in_valid = drv_valid & ~sel;
    assign a_in_data  = drv_data[31:0];
    assign b_in_valid = drv_valid & sel;
    assign b_in_data  = drv_data;

    fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut_a (
        .clk (clk), .rst_n (rst_n),
        .in_valid (a_in_valid), .in_ready (a_in_ready),
        .in_data (a_in_data), .in_mode (drv_mode),
        .out_valid (a_out_valid), .out_ready (out_rdy),
        .out_data (a_out_data)
`ifdef FP_ROUND_INEXACT_EN
        , .out_inexact (a_out_inexact)
`endif
    );

    fp_round_pipe #(.EXP_W(11), .MAN_W(52)) dut_b (
        .clk (clk), .rst_n (rst_n),
        .in_valid (b_in_valid), .in_ready (b_in_ready),
        .in_data (b_in_data), .in_mode (drv_mode),
        .out_valid (b_out_valid), .out_ready (out_rdy),
        .out_data (b_out_data)
`ifdef FP_ROUND_INEXACT_EN
        , .out_inexact (b_out_inexact)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Split |x| into integer q and remainder r, round q per mode, re-encode q.
    function automatic logic [63:0] rnd_model(input logic [63:0] x, input int ew,
                                              input int mw, input logic [1:0] md);
        int          bias;
        int          e;
        int          sh;
        int          p;
        logic        sgn;
        logic        nz;
        logic        up;
        logic [63:0] ex, man, m, q, r, half, res;
        bias = (1 << (ew - 1)) - 1;
        sgn  = x[ew + mw];
        ex   = (x >> mw) & ((64'd1 << ew) - 1);
        man  = x & ((64'd1 << mw) - 1);
        e    = int'(ex) - bias;
        if (ex == (64'd1 << ew) - 1 || e >= mw) return x;
        up = 1'b0;
        if (e < 0) begin
            nz = (ex != 0) || (man != 0);
            case (md)
                MODE_FLOOR: up = sgn && nz;
                MODE_CEIL:  up = !sgn && nz;
                MODE_RNE:   up = (e == -1) && (man != 0);  // |x| > 0.5
                default:    up = 1'b0;
            endcase
            q = {63'd0, up};
        end else begin
            m    = (64'd1 << mw) | man;
            sh   = mw - e;
            q    = m >> sh;
            r    = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            case (md)
                MODE_FLOOR: up = sgn && (r != 0);
                MODE_CEIL:  up = !sgn && (r != 0);
                MODE_RNE:   up = (r > half) || ((r == half) && q[0]);
                default:    up = 1'b0;
            endcase
            q = q + {63'd0, up};
        end
        res = {63'd0, sgn} << (ew + mw);
        if (q == 0) return res;
        p = 0;
        for (int i = 63; i >= 0; i--) begin
            if (q[i]) begin
                p = i;
                break;
            end
        end
        res = res | (64'(bias + p) << mw) | ((q << (mw - p)) & ((64'd1 << mw) - 1));
        return res;
    endfunction

    function automatic logic [63:0] rand_word(input int ew, input int mw);
        logic [63:0] man, ex;
        int          bias;
        int          k;
        bias = (1 << (ew - 1)) - 1;
        man  = {$urandom, $urandom} & ((64'd1 << mw) - 1);
        if ($urandom_range(0, 3) == 0) begin
            k   = int'($urandom_range(0, mw));
            man = man & ~((64'd1 << k) - 1);  // bias towards exact halves/integers
        end
        case ($urandom_range(0, 9))
            0:       ex = (64'd1 << ew) - 1;
            1:       ex = 64'd0;
            2:       ex = 64'($urandom_range(0, (1 << ew) - 1));
            default: ex = 64'(bias - 3 + int'($urandom_range(0, mw + 5)));
        endcase
        return (64'($urandom_range(0, 1)) << (ew + mw)) | (ex << mw) | man;
    endfunction

    // ---------------- scoreboard: expected queues {inexact, data} ----------------
    logic [32:0] exp_qa[$];
    logic [64:0] exp_qb[$];
    int          acc_qa[$];
    int          acc_qb[$];
    int          a_acc_cnt = 0;
    logic        a_hold = 1'b0, b_hold = 1'b0;
    logic [31:0] a_prev;
    logic [63:0] b_prev;

    always @(negedge clk) begin
        logic [63:0] res;
        logic [32:0] ea;
        logic [64:0] eb;
        int          t;
        if (!rst_n) begin
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            // held output must not move while stalled
            if (a_hold) begin
                check("a_hold_valid", a_out_valid, 1);
                check("a_hold_data", a_out_data, a_prev);
            end
            if (b_hold) begin
                check("b_hold_valid", b_out_valid, 1);
                check("b_hold_data", b_out_data, b_prev);
            end
            a_hold = a_out_valid && !out_rdy;
            b_hold = b_out_valid && !out_rdy;
            a_prev = a_out_data;
            b_prev = b_out_data;

            if (a_out_valid && out_rdy) begin
                if (exp_qa.size() == 0) begin
                    n_checks++;
                    $display("FAIL a_unexpected_out: got %h, expected no word", a_out_data);
                end else begin
                    ea = exp_qa.pop_front();
                    t  = acc_qa.pop_front();
                    check("a_data", a_out_data, ea[31:0]);
`ifdef FP_ROUND_INEXACT_EN
                    check("a_inexact", a_out_inexact, ea[32]);
`endif
                    if (chk_lat) check("a_latency", cyc - t, 2);
                end
            end
            if (b_out_valid && out_rdy) begin
                if (exp_qb.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_unexpected_out: got %h, expected no word", b_out_data);
                end else begin
                    eb = exp_qb.pop_front();
                    t  = acc_qb.pop_front();
                    check("b_data", b_out_data, eb[63:0]);
`ifdef FP_ROUND_INEXACT_EN
                    check("b_inexact", b_out_inexact, eb[64]);
`endif
                    if (chk_lat) check("b_latency", cyc - t, 2);
                end
            end

            if (a_in_valid && a_in_ready) begin
                res = rnd_model({32'd0, a_in_data}, 8, 23, drv_mode);
                exp_qa.push_back({res[31:0] != a_in_data, res[31:0]});
                acc_qa.push_back(cyc);
                a_acc_cnt++;
            end
            if (b_in_valid && b_in_ready) begin
                res = rnd_model(b_in_data, 11, 52, drv_mode);
                exp_qb.push_back({res != b_in_data, res});
                acc_qb.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks (call at posedge + 1) ----------------
    task automatic send(input logic [63:0] d, input logic [1:0] m);
        drv_valid = 1'b1;
        drv_data  = d;
        drv_mode  = m;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sel ? b_in_ready : a_in_ready) begin
                @(posedge clk);
                #1;
                drv_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1 within 2000 cycles");
        drv_valid = 1'b0;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_qa.size() == 0 && exp_qb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d/%0d words outstanding, required 0",
                     exp_qa.size(), exp_qb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int n, input logic use_b);
        sel     = use_b;
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(use_b ? rand_word(11, 52) : rand_word(8, 23), 2'($urandom_range(0, 3)));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_rdy = ($urandom_range(0, 99) < 70);
                end
            end
        join
        out_rdy = 1'b1;
        wait_drain();
    endtask

    // ---------------- directed vectors ----------------
    logic [31:0] dv_in[16];
    logic [1:0]  dv_md[16];
    logic [31:0] dv_exp[16];
    logic        dv_inx[16];
    logic [63:0] db_in[3];
    logic [1:0]  db_md[3];
    logic [63:0] db_exp[3];

    initial begin
        dv_in[0]  = 32'h40200000; dv_md[0]  = MODE_TRUNC; dv_exp[0]  = 32'h40000000; dv_inx[0]  = 1;
        dv_in[1]  = 32'h40200000; dv_md[1]  = MODE_FLOOR; dv_exp[1]  = 32'h40000000; dv_inx[1]  = 1;
        dv_in[2]  = 32'h40200000; dv_md[2]  = MODE_CEIL;  dv_exp[2]  = 32'h40400000; dv_inx[2]  = 1;
        dv_in[3]  = 32'h40200000; dv_md[3]  = MODE_RNE;   dv_exp[3]  = 32'h40000000; dv_inx[3]  = 1;
        dv_in[4]  = 32'hC0200000; dv_md[4]  = MODE_FLOOR; dv_exp[4]  = 32'hC0400000; dv_inx[4]  = 1;
        dv_in[5]  = 32'h40600000; dv_md[5]  = MODE_RNE;   dv_exp[5]  = 32'h40800000; dv_inx[5]  = 1;
        dv_in[6]  = 32'h3F000000; dv_md[6]  = MODE_RNE;   dv_exp[6]  = 32'h00000000; dv_inx[6]  = 1;
        dv_in[7]  = 32'h3F400000; dv_md[7]  = MODE_RNE;   dv_exp[7]  = 32'h3F800000; dv_inx[7]  = 1;
        dv_in[8]  = 32'h3FFFFFFF; dv_md[8]  = MODE_CEIL;  dv_exp[8]  = 32'h40000000; dv_inx[8]  = 1;
        dv_in[9]  = 32'hBFFFFFFF; dv_md[9]  = MODE_FLOOR; dv_exp[9]  = 32'hC0000000; dv_inx[9]  = 1;
        dv_in[10] = 32'hBE800000; dv_md[10] = MODE_FLOOR; dv_exp[10] = 32'hBF800000; dv_inx[10] = 1;
        dv_in[11] = 32'hBE800000; dv_md[11] = MODE_CEIL;  dv_exp[11] = 32'h80000000; dv_inx[11] = 1;
        dv_in[12] = 32'h7FC00000; dv_md[12] = MODE_RNE;   dv_exp[12] = 32'h7FC00000; dv_inx[12] = 0;
        dv_in[13] = 32'hFF800000; dv_md[13] = MODE_FLOOR; dv_exp[13] = 32'hFF800000; dv_inx[13] = 0;
        dv_in[14] = 32'h4B000001; dv_md[14] = MODE_CEIL;  dv_exp[14] = 32'h4B000001; dv_inx[14] = 0;
        dv_in[15] = 32'h80000000; dv_md[15] = MODE_FLOOR; dv_exp[15] = 32'h80000000; dv_inx[15] = 0;
        db_in[0] = 64'h4004000000000000; db_md[0] = MODE_CEIL;  db_exp[0] = 64'h4008000000000000;
        db_in[1] = 64'h3FE0000000000000; db_md[1] = MODE_RNE;   db_exp[1] = 64'h0000000000000000;
        db_in[2] = 64'hBFF8000000000000; db_md[2] = MODE_RNE;   db_exp[2] = 64'hC000000000000000;
    end

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] mres;
        int          base;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_out_data", b_out_data, 0);
        check("rst_b_in_ready", b_in_ready, 1);
`ifdef FP_ROUND_INEXACT_EN
        check("rst_a_inexact", a_out_inexact, 0);
        check("rst_b_inexact", b_out_inexact, 0);
`endif
        @(posedge clk);
        #1;

        // Directed single precision, back to back, latency exactly 2.
        sel     = 1'b0;
        out_rdy = 1'b1;
        chk_lat = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mres = rnd_model({32'd0, dv_in[i]}, 8, 23, dv_md[i]);
            check("model_pin_s", mres, {32'd0, dv_exp[i]});
            check("model_pin_s_inexact", mres[31:0] != dv_in[i], dv_inx[i]);
        end
        for (int i = 0; i < 16; i++) send({32'd0, dv_in[i]}, dv_md[i]);
        wait_drain();

        // Directed double precision.
        sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("model_pin_d", rnd_model(db_in[i], 11, 52, db_md[i]), db_exp[i]);
        end
        for (int i = 0; i < 3; i++) send(db_in[i], db_md[i]);
        wait_drain();
        chk_lat = 1'b0;

        // Backpressure: 4 words, output stalled, at most 2 accepted.
        sel     = 1'b0;
        out_rdy = 1'b0;
        base    = a_acc_cnt;
        fork
            begin
                send(64'h40200000, MODE_TRUNC);
                send(64'h40600000, MODE_RNE);
                send(64'h3F400000, MODE_RNE);
                send(64'hC0200000, MODE_FLOOR);
            end
            begin
                repeat (6) @(negedge clk);
                check("bp_in_ready", a_in_ready, 0);
                check("bp_accepted", a_acc_cnt - base, 2);
                check("bp_out_valid", a_out_valid, 1);
                check("bp_head", a_out_data, 64'h40000000);
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_drain();
        check("bp_total_accepted", a_acc_cnt - base, 4);

        // Reset with two words in flight.
        out_rdy = 1'b0;
        send(64'h40200000, MODE_CEIL);
        send(64'h3F400000, MODE_RNE);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_in_ready", a_in_ready, 1);
        exp_qa.delete();
        acc_qa.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        chk_lat = 1'b1;
        send(64'hC0200000, MODE_FLOOR);
        wait_drain();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk_lat = 1'b0;

        // Random valid/ready traffic on both formats.
        run_random(10000, 1'b0);
        run_random(4000, 1'b1);

        check("end_queue_a", exp_qa.size(), 0);
        check("end_queue_b", exp_qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
